// File: rtl/decoder_scan_seq.sv
// Registered one-hot decoder with a dwell-timed scan mode for row/strobe selection.
// Optional macro DEC_SKIP_MASK_EN adds i_skip_mask to choose which indices the scan visits.
module decoder_scan_seq #(
   parameter int unsigned SEL_W = 3,
   parameter int unsigned DWELL = 4,
   localparam int unsigned OUT_W = 2**SEL_W
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_mode,
   input  logic [SEL_W-1:0] i_in,
`ifdef DEC_SKIP_MASK_EN
   input  logic [OUT_W-1:0] i_skip_mask,
`endif
   output logic [OUT_W-1:0] o_out,
   output logic [SEL_W-1:0] o_idx,
   output logic             o_active,
   output logic             o_wrap
);

   localparam int unsigned CNT_W = $clog2(DWELL) + 1;

   typedef enum logic [1:0] {StIdle, StDirect, StScan} state_e;

   state_e           r_state, w_state_d;
   logic [OUT_W-1:0] r_out, w_out_d;
   logic [SEL_W-1:0] r_idx, w_idx_d;
   logic [CNT_W-1:0] r_dwell, w_dwell_d;
   logic             r_active, r_wrap, w_wrap_d;

   // Index the scan moves to at the end of a dwell period.
   logic [SEL_W-1:0] w_adv_idx;
   logic             w_adv_found;
   logic             w_adv_wrap;

`ifdef DEC_SKIP_MASK_EN
   logic [SEL_W-1:0] w_cand;

   // Nearest enabled index after r_idx; distance OUT_W lands back on r_idx itself.
   always_comb begin
      w_adv_idx   = r_idx;
      w_adv_found = 1'b0;
      w_cand      = r_idx;
      for (int unsigned d = 1; d <= OUT_W; d++) begin
         w_cand = r_idx + SEL_W'(d);
         if (!w_adv_found && i_skip_mask[w_cand]) begin
            w_adv_idx   = w_cand;
            w_adv_found = 1'b1;
         end
      end
      w_adv_wrap = w_adv_found && (w_adv_idx <= r_idx);
   end
`else
   assign w_adv_idx   = r_idx + SEL_W'(1);
   assign w_adv_found = 1'b1;
   assign w_adv_wrap  = (r_idx == SEL_W'(OUT_W - 1));
`endif

   always_comb begin
      w_state_d = r_state;
      w_out_d   = r_out;
      w_idx_d   = r_idx;
      w_dwell_d = r_dwell;
      w_wrap_d  = 1'b0;
      if (!i_en) begin
         w_state_d = StIdle;
         w_out_d   = '0;
         w_dwell_d = '0;
      end else if (r_state == StScan && i_mode) begin
         if (r_dwell == CNT_W'(DWELL - 1)) begin
            w_dwell_d = '0;
            if (w_adv_found) begin
               w_idx_d  = w_adv_idx;
               w_out_d  = OUT_W'(1) << w_adv_idx;
               w_wrap_d = w_adv_wrap;
            end else begin
               w_out_d = '0;
            end
         end else begin
            w_dwell_d = r_dwell + CNT_W'(1);
         end
      end else begin
         // Entry into DIRECT or SCAN, or a DIRECT refresh: both load from i_in.
         w_state_d = i_mode ? StScan : StDirect;
         w_out_d   = OUT_W'(1) << i_in;
         w_idx_d   = i_in;
         w_dwell_d = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= StIdle;
         r_out    <= '0;
         r_idx    <= '0;
         r_dwell  <= '0;
         r_active <= 1'b0;
         r_wrap   <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         r_out    <= w_out_d;
         r_idx    <= w_idx_d;
         r_dwell  <= w_dwell_d;
         r_active <= |w_out_d;
         r_wrap   <= w_wrap_d;
      end
   end

   assign o_out    = r_out;
   assign o_idx    = r_idx;
   assign o_active = r_active;
   assign o_wrap   = r_wrap;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Directed bench for decoder_scan_seq: an 8-way DWELL=4 instance and a 4-way DWELL=1 instance.
// With DEC_SKIP_MASK_EN defined the skip-mask scan is exercised on the 8-way instance.
module tb_decoder_scan_seq;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_rst, a_en, a_mode;
   logic [2:0] a_in;
   logic [7:0] a_out;
   logic [2:0] a_idx;
   logic       a_active, a_wrap;
`ifdef DEC_SKIP_MASK_EN
   logic [7:0] a_mask;
`endif

   logic       b_rst, b_en, b_mode;
   logic [1:0] b_in;
   logic [3:0] b_out;
   logic [1:0] b_idx;
   logic       b_active, b_wrap;

   int n_total = 0;
   int n_pass  = 0;

   decoder_scan_seq #(.SEL_W(3), .DWELL(4)) u_dut_a (
      .i_clk      (clk),
      .i_rst      (a_rst),
      .i_en       (a_en),
      .i_mode     (a_mode),
      .i_in       (a_in),
`ifdef DEC_SKIP_MASK_EN
      .i_skip_mask(a_mask),
`endif
      .o_out      (a_out),
      .o_idx      (a_idx),
      .o_active   (a_active),
      .o_wrap     (a_wrap)
   );

   decoder_scan_seq #(.SEL_W(2), .DWELL(1)) u_dut_b (
      .i_clk      (clk),
      .i_rst      (b_rst),
      .i_en       (b_en),
      .i_mode     (b_mode),
      .i_in       (b_in),
`ifdef DEC_SKIP_MASK_EN
      .i_skip_mask(4'hF),
`endif
      .o_out      (b_out),
      .o_idx      (b_idx),
      .o_active   (b_active),
      .o_wrap     (b_wrap)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance n edges on instance A, checking that out holds exp and wrap stays low.
   task automatic a_hold(input string tag, input int n, input logic [7:0] exp);
      for (int i = 0; i < n; i++) begin
         step();
         check(tag, {24'd0, a_out}, {24'd0, exp});
         check({tag, "_wrap"}, {31'd0, a_wrap}, 32'd0);
      end
   endtask

   logic [3:0] b_exp_out  [6];
   logic       b_exp_wrap [6];

   initial begin
      a_rst = 1'b1; a_en = 1'b0; a_mode = 1'b0; a_in = 3'd0;
      b_rst = 1'b1; b_en = 1'b0; b_mode = 1'b0; b_in = 2'd0;
`ifdef DEC_SKIP_MASK_EN
      a_mask = 8'hFF;
`endif
      step();
      step();
      check("rst_out",    {24'd0, a_out},    32'h0);
      check("rst_idx",    {29'd0, a_idx},    32'h0);
      check("rst_active", {31'd0, a_active}, 32'h0);
      check("rst_wrap",   {31'd0, a_wrap},   32'h0);

      // Direct decode, one cycle latency.
      a_rst = 1'b0; a_en = 1'b1; a_mode = 1'b0; a_in = 3'd5;
      step();
      check("dir5_out",    {24'd0, a_out},    32'h20);
      check("dir5_idx",    {29'd0, a_idx},    32'd5);
      check("dir5_active", {31'd0, a_active}, 32'd1);
      check("dir5_wrap",   {31'd0, a_wrap},   32'd0);
      a_in = 3'd0;
      step();
      check("dir0_out", {24'd0, a_out}, 32'h01);
      check("dir0_idx", {29'd0, a_idx}, 32'd0);

      // Scan from 6: four cycles at 6, four at 7, then wrap to 0; in ignored after entry.
      a_mode = 1'b1; a_in = 3'd6;
      step();
      check("scan6_entry", {24'd0, a_out}, 32'h40);
      a_in = 3'd1;
      a_hold("scan6", 3, 8'h40);
      a_hold("scan7", 4, 8'h80);
      step();
      check("wrap_out",    {24'd0, a_out},  32'h01);
      check("wrap_idx",    {29'd0, a_idx},  32'd0);
      check("wrap_pulse",  {31'd0, a_wrap}, 32'd1);
      a_hold("scan0", 3, 8'h01);
      step();
      check("scan1_out", {24'd0, a_out}, 32'h02);
      check("scan1_idx", {29'd0, a_idx}, 32'd1);

      // Drop enable for one cycle: outputs clear, idx holds.
      a_en = 1'b0;
      step();
      check("en0_out",    {24'd0, a_out},    32'h0);
      check("en0_active", {31'd0, a_active}, 32'd0);
      check("en0_idx",    {29'd0, a_idx},    32'd1);
      a_en = 1'b1; a_in = 3'd2;
      step();
      check("reen_out", {24'd0, a_out}, 32'h04);
      a_hold("reen2", 3, 8'h04);
      step();
      check("reen3_out", {24'd0, a_out}, 32'h08);
      check("reen3_idx", {29'd0, a_idx}, 32'd3);

      // Reset mid-dwell at idx 3.
      step();
      a_rst = 1'b1;
      step();
      check("rst2_out",    {24'd0, a_out},    32'h0);
      check("rst2_idx",    {29'd0, a_idx},    32'h0);
      check("rst2_active", {31'd0, a_active}, 32'h0);
      a_rst = 1'b0; a_en = 1'b1; a_mode = 1'b0; a_in = 3'd7;
      step();
      check("post_rst_out", {24'd0, a_out}, 32'h80);
      check("post_rst_idx", {29'd0, a_idx}, 32'd7);

      // Scan entry then immediate return to direct discards the scan position.
      a_mode = 1'b1; a_in = 3'd3;
      step();
      check("sc3_out", {24'd0, a_out}, 32'h08);
      a_mode = 1'b0; a_in = 3'd4;
      step();
      check("todir_out",  {24'd0, a_out},  32'h10);
      check("todir_idx",  {29'd0, a_idx},  32'd4);
      check("todir_wrap", {31'd0, a_wrap}, 32'd0);

`ifdef DEC_SKIP_MASK_EN
      // Mask 1001_0001 visits 0 -> 4 -> 7 -> 0.
      a_mask = 8'b1001_0001; a_mode = 1'b1; a_in = 3'd0;
      step();
      check("msk_entry", {24'd0, a_out}, 32'h01);
      a_hold("msk0", 3, 8'h01);
      step();
      check("msk4_out", {24'd0, a_out}, 32'h10);
      check("msk4_idx", {29'd0, a_idx}, 32'd4);
      a_hold("msk4", 3, 8'h10);
      step();
      check("msk7_out",  {24'd0, a_out},  32'h80);
      check("msk7_wrap", {31'd0, a_wrap}, 32'd0);
      a_hold("msk7", 3, 8'h80);
      step();
      check("mskw_out",  {24'd0, a_out},  32'h01);
      check("mskw_wrap", {31'd0, a_wrap}, 32'd1);
      a_mask = 8'h00;
      a_hold("mskz_hold", 3, 8'h01);
      step();
      check("mskz_out",    {24'd0, a_out},    32'h0);
      check("mskz_active", {31'd0, a_active}, 32'd0);
      check("mskz_idx",    {29'd0, a_idx},    32'd0);
      a_mask = 8'b1001_0001;
      a_hold("mskz_idle", 3, 8'h00);
      step();
      check("mskr_out",    {24'd0, a_out},    32'h10);
      check("mskr_active", {31'd0, a_active}, 32'd1);
`endif

      // Instance B: SEL_W=2, DWELL=1 advances every cycle.
      b_exp_out  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
      b_exp_wrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      b_rst = 1'b0; b_en = 1'b1; b_mode = 1'b1; b_in = 2'd0;
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("b_scan_out%0d", i),  {28'd0, b_out},  {28'd0, b_exp_out[i]});
         check($sformatf("b_scan_wrap%0d", i), {31'd0, b_wrap}, {31'd0, b_exp_wrap[i]});
      end
      b_mode = 1'b0; b_in = 2'd1;
      step();
      check("b_dir_out",  {28'd0, b_out},  32'h2);
      check("b_dir_idx",  {30'd0, b_idx},  32'd1);
      check("b_dir_wrap", {31'd0, b_wrap}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
